// File: rtl/qeciphy_rx_link_ctrl.sv
// Receive-side link bring-up: pulses the channel decoder reset, waits for alignment, retries on errors and faults out after too many.
// Latency: every output is registered from the next state and moves on the same edge as the state.
// Backpressure: none; error counters saturate, and the sticky decoder flags count only once per LINK_UP exit.
module qeciphy_rx_link_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_clear_fault,
    input  logic        i_dec_rx_rdy,
    input  logic        i_dec_fap_missing,
    input  logic        i_dec_crc_mismatch,
    output logic        o_dec_rst_n,
    output logic        o_link_up,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic [3:0]  o_retry_count,
    output logic [15:0] o_fap_err_count,
    output logic [15:0] o_crc_err_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_FAW     = 2'b10;
    localparam logic [1:0] CAUSE_CRC     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT_RDY,
        S_LINK_UP,
        S_FAULT
    } state_t;

    state_t          r_state;
    logic [HW-1:0]   r_hold_tmr;
    logic [TW-1:0]   r_to_tmr;
    logic            r_dec_rst_n;
    logic            r_link_up;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic [3:0]      r_retry_cnt;
    logic [15:0]     r_fap_cnt;
    logic [15:0]     r_crc_cnt;

    state_t          w_nxt;
    logic            w_retry;
    logic [1:0]      w_cause;

    // A failed attempt is resolved in the same cycle it is detected: back to HOLD or on to FAULT.
    always_comb begin
        w_nxt   = r_state;
        w_retry = 1'b0;
        w_cause = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (i_enable) w_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!i_enable)                 w_nxt = S_IDLE;
                else if (r_hold_tmr == HOLD_LAST) w_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!i_enable)                 w_nxt = S_IDLE;
                else if (i_dec_rx_rdy)         w_nxt = S_LINK_UP;
                else if (r_to_tmr == TO_LAST) begin
                    w_retry = 1'b1;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_LINK_UP: begin
                if (!i_enable) begin
                    w_nxt = S_IDLE;
                end else if (i_dec_fap_missing) begin
                    w_retry = 1'b1;
                    w_cause = CAUSE_FAW;
                end else if (i_dec_crc_mismatch) begin
                    w_retry = 1'b1;
                    w_cause = CAUSE_CRC;
                end else if (!i_dec_rx_rdy) begin
                    w_retry = 1'b1;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_FAULT: begin
                if (i_clear_fault) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
        if (w_retry) w_nxt = (r_retry_cnt == RETRY_MAX) ? S_FAULT : S_HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hold_tmr   <= '0;
            r_to_tmr     <= '0;
            r_dec_rst_n  <= 1'b0;
            r_link_up    <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_retry_cnt  <= 4'd0;
            r_fap_cnt    <= 16'd0;
            r_crc_cnt    <= 16'd0;
        end else begin
            r_state     <= w_nxt;
            r_dec_rst_n <= (w_nxt == S_WAIT_RDY) || (w_nxt == S_LINK_UP);
            r_link_up   <= (w_nxt == S_LINK_UP);
            r_fault     <= (w_nxt == S_FAULT);

            // Timers restart from zero on every entry, so they can never run past their terminal value.
            r_hold_tmr <= (r_state == S_HOLD && w_nxt == S_HOLD) ? r_hold_tmr + 1'b1 : '0;
            r_to_tmr   <= (r_state == S_WAIT_RDY && w_nxt == S_WAIT_RDY) ? r_to_tmr + 1'b1 : '0;

            if (w_retry) begin
                if (r_retry_cnt != RETRY_MAX) r_retry_cnt <= r_retry_cnt + 4'd1;
            end else if (w_nxt == S_LINK_UP || w_nxt == S_IDLE) begin
                r_retry_cnt <= 4'd0;
            end

            if (w_retry)
                r_fault_code <= w_cause;
            else if ((r_state == S_IDLE && w_nxt == S_HOLD) || (r_state == S_FAULT && w_nxt == S_IDLE))
                r_fault_code <= 2'b00;

            if (w_retry && r_state == S_LINK_UP) begin
                if (i_dec_fap_missing && r_fap_cnt != 16'hFFFF)  r_fap_cnt <= r_fap_cnt + 16'd1;
                if (i_dec_crc_mismatch && r_crc_cnt != 16'hFFFF) r_crc_cnt <= r_crc_cnt + 16'd1;
            end
        end
    end

    assign o_dec_rst_n     = r_dec_rst_n;
    assign o_link_up       = r_link_up;
    assign o_fault         = r_fault;
    assign o_fault_code    = r_fault_code;
    assign o_retry_count   = r_retry_cnt;
    assign o_fap_err_count = r_fap_cnt;
    assign o_crc_err_count = r_crc_cnt;

endmodule

// File: tb/tb_qeciphy_rx_link_ctrl.sv
// Directed bench for qeciphy_rx_link_ctrl: stimulus queues the expected output snapshot and edge number,
// a monitor compares whenever the DUT outputs change.
module tb_qeciphy_rx_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_clear_fault;
    logic        i_dec_rx_rdy;
    logic        i_dec_fap_missing;
    logic        i_dec_crc_mismatch;
    logic        o_dec_rst_n;
    logic        o_link_up;
    logic        o_fault;
    logic [1:0]  o_fault_code;
    logic [3:0]  o_retry_count;
    logic [15:0] o_fap_err_count;
    logic [15:0] o_crc_err_count;

    qeciphy_rx_link_ctrl #(
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(32),
        .MAX_RETRIES   (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_enable          (i_enable),
        .i_clear_fault     (i_clear_fault),
        .i_dec_rx_rdy      (i_dec_rx_rdy),
        .i_dec_fap_missing (i_dec_fap_missing),
        .i_dec_crc_mismatch(i_dec_crc_mismatch),
        .o_dec_rst_n       (o_dec_rst_n),
        .o_link_up         (o_link_up),
        .o_fault           (o_fault),
        .o_fault_code      (o_fault_code),
        .o_retry_count     (o_retry_count),
        .o_fap_err_count   (o_fap_err_count),
        .o_crc_err_count   (o_crc_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dec_rst_n;
        logic        link_up;
        logic        fault;
        logic [1:0]  code;
        logic [3:0]  retry;
        logic [15:0] fap;
        logic [15:0] crc;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
        string nm;
    } item_t;

    item_t exp_q[$];
    outs_t exp;
    outs_t prev;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    first = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector must match the next queued expectation, at its edge.
    always @(negedge clk) begin
        outs_t cur;
        item_t it;
        if (mon_en) begin
            cur = '{o_dec_rst_n, o_link_up, o_fault, o_fault_code, o_retry_count,
                    o_fap_err_count, o_crc_err_count};
            if (first || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: edge %0d outs %h, required no change", cyc, cur);
                end else begin
                    it = exp_q.pop_front();
                    if (it.cyc != cyc || cur !== it.o) begin
                        errors++;
                        $display("FAIL %s: edge %0d outs %h, required edge %0d outs %h",
                                 it.nm, cyc, cur, it.cyc, it.o);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input string nm);
        item_t it;
        it.cyc = cyc + d;
        it.o   = exp;
        it.nm  = nm;
        exp_q.push_back(it);
    endtask

    task automatic relink(input string nm);
        exp.dec_rst_n = 1'b1;
        expect_at(5, {nm, "_wait"});
        exp.link_up = 1'b1;
        exp.retry   = 4'd0;
        expect_at(6, {nm, "_relink"});
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b0; i_clear_fault = 1'b0;
        i_dec_rx_rdy = 1'b0; i_dec_fap_missing = 1'b0; i_dec_crc_mismatch = 1'b0;
        step(3);
        exp = '0;
        expect_at(0, "reset_state");
        mon_en = 1'b1;

        // Bring-up: 4 hold cycles, ready arrives 10 cycles after decoder release.
        rst = 1'b0; i_enable = 1'b1;
        exp.dec_rst_n = 1'b1;
        expect_at(5, "hold4_release");
        step(14);
        i_dec_rx_rdy = 1'b1;
        exp.link_up = 1'b1;
        expect_at(1, "link_up");
        step(4);

        // FAW and CRC together: both counters, cause FAW.
        i_dec_fap_missing = 1'b1; i_dec_crc_mismatch = 1'b1;
        exp = '{1'b0, 1'b0, 1'b0, 2'b10, 4'd1, 16'd1, 16'd1};
        expect_at(1, "dual_err");
        relink("dual");
        step(1);
        i_dec_fap_missing = 1'b0; i_dec_crc_mismatch = 1'b0;
        step(8);

        // CRC counter saturation from a preload.
        dut.r_crc_cnt = 16'hFFFE;
        exp.crc = 16'hFFFE;
        expect_at(0, "preload");
        step(1);
        i_dec_crc_mismatch = 1'b1;
        exp.dec_rst_n = 1'b0; exp.link_up = 1'b0; exp.code = 2'b11; exp.retry = 4'd1; exp.crc = 16'hFFFF;
        expect_at(1, "crc_to_max");
        relink("crc1");
        step(1);
        i_dec_crc_mismatch = 1'b0;
        step(8);
        i_dec_crc_mismatch = 1'b1;
        exp.dec_rst_n = 1'b0; exp.link_up = 1'b0; exp.retry = 4'd1;
        expect_at(1, "crc_saturated");
        relink("crc2");
        step(1);
        i_dec_crc_mismatch = 1'b0;
        step(8);

        // Disable together with a CRC flag: IDLE, nothing counted, cause kept.
        i_enable = 1'b0; i_dec_crc_mismatch = 1'b1;
        exp.dec_rst_n = 1'b0; exp.link_up = 1'b0;
        expect_at(1, "disable_wins");
        step(1);
        i_dec_crc_mismatch = 1'b0;
        step(3);

        // Ready stuck low: three 32-cycle windows, then FAULT.
        i_enable = 1'b1; i_dec_rx_rdy = 1'b0;
        exp.code = 2'b00;
        expect_at(1, "idle_clears_code");
        exp.dec_rst_n = 1'b1;                                   expect_at(5,   "to_wait1");
        exp.dec_rst_n = 1'b0; exp.code = 2'b01; exp.retry = 4'd1; expect_at(37,  "timeout1");
        exp.dec_rst_n = 1'b1;                                   expect_at(41,  "to_wait2");
        exp.dec_rst_n = 1'b0; exp.retry = 4'd2;                 expect_at(73,  "timeout2");
        exp.dec_rst_n = 1'b1;                                   expect_at(77,  "to_wait3");
        exp.dec_rst_n = 1'b0; exp.fault = 1'b1;                 expect_at(109, "fault");
        step(115);

        // Clear the fault with enable still high: IDLE, then HOLD, then two more timeouts.
        i_clear_fault = 1'b1;
        exp.fault = 1'b0; exp.retry = 4'd0; exp.code = 2'b00;
        expect_at(1, "clear_fault");
        exp.dec_rst_n = 1'b1;                                   expect_at(6,  "rehold_wait");
        exp.dec_rst_n = 1'b0; exp.code = 2'b01; exp.retry = 4'd1; expect_at(38, "re_timeout1");
        exp.dec_rst_n = 1'b1;                                   expect_at(42, "re_wait2");
        exp.dec_rst_n = 1'b0; exp.retry = 4'd2;                 expect_at(74, "re_timeout2");
        exp.dec_rst_n = 1'b1;                                   expect_at(78, "re_wait3");
        step(1);
        i_clear_fault = 1'b0;
        step(79);

        // Reset in WAIT_RDY with two retries consumed; reset beats enable and clear_fault.
        rst = 1'b1; i_clear_fault = 1'b1;
        exp = '0;
        expect_at(1, "mid_reset");
        step(2);
        rst = 1'b0; i_clear_fault = 1'b0; i_enable = 1'b0;
        step(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected changes never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
